// File: rtl/dma_stream_proc.sv
// AFU-side DMA client: launches matching read/write transfers and streams each cacheline
// from the read FIFO to the write port with a per-lane 32-bit addend applied.
module dma_stream_proc #(
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 512,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH:0]   size,
    input  logic [31:0]           incr,
    output logic                  busy,
    output logic                  done,
    output logic                  dma_rd_go,
    output logic                  dma_wr_go,
    output logic [ADDR_WIDTH-1:0] dma_rd_addr,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [ADDR_WIDTH:0]   dma_rd_size,
    output logic                  dma_rd_en,
    input  logic [DATA_WIDTH-1:0] dma_rd_data,
    input  logic                  dma_empty,
    output logic                  dma_wr_en,
    output logic [DATA_WIDTH-1:0] dma_wr_data,
    input  logic                  dma_full,
    input  logic                  dma_rd_done,
    input  logic                  dma_wr_done
);
    localparam int SW    = ADDR_WIDTH + 1;
    localparam int LANES = DATA_WIDTH / 32;
    localparam int QAW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int QCW   = QAW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic [SW-1:0]         size_q, incr_unused_w;
    logic [31:0]           incr_q;
    logic [SW-1:0]         rcnt_q, rcnt_d, wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0] s1_q;
    logic                  s1_vld_q;
    logic [DATA_WIDTH-1:0] q_mem [QUEUE_DEPTH];
    logic [QAW-1:0]        q_wptr_q, q_rptr_q;
    logic [QCW-1:0]        q_cnt_q, q_cnt_d, credits;
    logic                  accept, in_run, push, pop;

    // Lane-wise modular add; carries never cross a 32-bit lane boundary.
    function automatic logic [DATA_WIDTH-1:0] add_lanes(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [31:0] inc);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[32*i +: 32] = d[32*i +: 32] + inc;
        end
        return r;
    endfunction

    assign incr_unused_w = '0;
    assign accept   = go && (state_q == S_IDLE || state_q == S_DONE);
    assign in_run   = (state_q == S_RUN);
    assign credits  = q_cnt_q + QCW'(s1_vld_q);
    assign dma_rd_en = in_run && !dma_empty && (rcnt_q < size_q) && (credits < QCW'(QUEUE_DEPTH));
    assign dma_wr_en = in_run && (q_cnt_q != '0) && !dma_full;
    assign push      = s1_vld_q;
    assign pop       = dma_wr_en;

    assign busy        = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_WAIT);
    assign done        = (state_q == S_DONE);
    assign dma_rd_go   = (state_q == S_START);
    assign dma_wr_go   = (state_q == S_START);
    assign dma_rd_addr = rd_addr_q;
    assign dma_wr_addr = wr_addr_q;
    assign dma_rd_size = size_q;
    assign dma_wr_data = q_mem[q_rptr_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (go) state_d = (size != '0) ? S_START : S_DONE;
            S_START:        state_d = S_RUN;
            S_RUN:          if (pop && (wcnt_q + SW'(1) == size_q)) state_d = S_WAIT;
            S_WAIT:         if (dma_rd_done && dma_wr_done) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rcnt_d  = accept ? '0 : (dma_rd_en ? rcnt_q + SW'(1) : rcnt_q);
        wcnt_d  = accept ? '0 : (pop ? wcnt_q + SW'(1) : wcnt_q);
        q_cnt_d = q_cnt_q;
        case ({push, pop})
            2'b10:   q_cnt_d = q_cnt_q + QCW'(1);
            2'b01:   q_cnt_d = q_cnt_q - QCW'(1);
            default: q_cnt_d = q_cnt_q;
        endcase
    end

    // Control state: FSM, counters, stage-1 valid and queue bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rcnt_q   <= '0;
            wcnt_q   <= '0;
            s1_vld_q <= 1'b0;
            q_wptr_q <= '0;
            q_rptr_q <= '0;
            q_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            wcnt_q   <= wcnt_d;
            s1_vld_q <= dma_rd_en;
            q_cnt_q  <= q_cnt_d;
            if (push) q_wptr_q <= q_wptr_q + QAW'(1);
            if (pop)  q_rptr_q <= q_rptr_q + QAW'(1);
        end
    end

    // Datapath: command latches, stage-1 sum and queue storage carry no reset.
    always_ff @(posedge clk) begin
        if (accept && size != '0) begin
            rd_addr_q <= rd_addr;
            wr_addr_q <= wr_addr;
            size_q    <= size;
            incr_q    <= incr;
        end
        if (dma_rd_en) s1_q <= add_lanes(dma_rd_data, incr_q);
        if (push)      q_mem[q_wptr_q] <= s1_q;
    end
endmodule

// File: tb/tb_dma_stream_proc.sv
// Directed bench for dma_stream_proc with a simple FIFO-head model and write-capture monitor.
module tb_dma_stream_proc;
    localparam int AW = 48;
    localparam int DW = 512;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [AW:0]   size;
    logic [31:0]   incr;
    logic          busy, done, dma_rd_go, dma_wr_go;
    logic [AW-1:0] dma_rd_addr, dma_wr_addr;
    logic [AW:0]   dma_rd_size;
    logic          dma_rd_en, dma_empty, dma_wr_en, dma_full, dma_rd_done, dma_wr_done;
    logic [DW-1:0] dma_rd_data, dma_wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int rptr = 0;
    int mode = 0;
    int cyc = 0, rd_go_cnt = 0, wr_go_cnt = 0, pops = 0, first_rd = -1, first_wr = -1;
    logic [DW-1:0] wq[$];

    always #5 clk = ~clk;

    dma_stream_proc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .rd_addr(rd_addr), .wr_addr(wr_addr),
        .size(size), .incr(incr), .busy(busy), .done(done),
        .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
        .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr), .dma_rd_size(dma_rd_size),
        .dma_rd_en(dma_rd_en), .dma_rd_data(dma_rd_data), .dma_empty(dma_empty),
        .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data), .dma_full(dma_full),
        .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done)
    );

    function automatic logic [DW-1:0] src_word(input int k, input int m);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++)
            w[32*i +: 32] = (m == 0) ? 32'(k * 16 + i) : 32'((i + k) % 2);
        return w;
    endfunction

    function automatic logic [DW-1:0] exp_plain(input int k, input logic [31:0] inc);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = 32'(k * 16 + i) + inc;
        return w;
    endfunction

    function automatic logic [DW-1:0] exp_wrap(input int k);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = ((i + k) % 2 == 1) ? 32'h0 : 32'hFFFF_FFFF;
        return w;
    endfunction

    always_comb dma_rd_data = src_word(rptr, mode);

    // FIFO head model: the DMA engine restarts its read stream on each read go.
    always @(posedge clk) begin
        if (dma_rd_go) rptr <= 0;
        else if (dma_rd_en) rptr <= rptr + 1;
    end

    always @(negedge clk) begin
        cyc++;
        if (dma_rd_go) rd_go_cnt++;
        if (dma_wr_go) wr_go_cnt++;
        if (dma_rd_en) begin
            pops++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (dma_wr_en) begin
            wq.push_back(dma_wr_data);
            if (first_wr < 0) first_wr = cyc;
        end
    end

    task automatic clear_mon();
        rd_go_cnt = 0; wr_go_cnt = 0; pops = 0; first_rd = -1; first_wr = -1;
        wq.delete();
    endtask

    task automatic do_go(input logic [AW:0] sz, input logic [31:0] inc,
                         input logic [AW-1:0] ra, input logic [AW-1:0] wa);
        @(posedge clk); #1;
        go = 1'b1; size = sz; incr = inc; rd_addr = ra; wr_addr = wa;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int t = 0;
        while (wq.size() < n && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        n_checks++;
        if (wq.size() < n) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d writes, required %0d", name, wq.size(), n);
        end
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done=%b busy=%b, required done=1 busy=0", name, done, busy);
        end
    endtask

    task automatic check_words(input int n, input int kind, input logic [31:0] inc, input string name);
        logic [DW-1:0] e;
        for (int k = 0; k < n; k++) begin
            e = (kind == 0) ? exp_plain(k, inc) : exp_wrap(k);
            n_checks++;
            if (k >= wq.size()) begin
                n_fail++;
                $display("FAIL %s_word%0d: missing, required %h", name, k, e);
            end else if (wq[k] !== e) begin
                n_fail++;
                $display("FAIL %s_word%0d: got %h required %h", name, k, wq[k], e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            go = 1'($urandom); size = 49'($urandom); incr = $urandom;
            rd_addr = 48'($urandom); wr_addr = 48'($urandom);
            dma_empty = 1'($urandom); dma_full = 1'($urandom);
            dma_rd_done = 1'($urandom); dma_wr_done = 1'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if ({busy, done, dma_rd_en, dma_wr_en, dma_rd_go, dma_wr_go} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: busy,done,rd_en,wr_en,rd_go,wr_go=%b required 000000",
                         {busy, done, dma_rd_en, dma_wr_en, dma_rd_go, dma_wr_go});
            end
        end
        go = 1'b0; dma_empty = 1'b0; dma_full = 1'b0; dma_rd_done = 1'b1; dma_wr_done = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_size0();
        clear_mon();
        do_go('0, 32'd9, 48'h5, 48'h6);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL size0_done: done=%b busy=%b, required done=1 busy=0", done, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rd_go_cnt != 0 || wr_go_cnt != 0 || pops != 0) begin
            n_fail++;
            $display("FAIL size0_no_pulses: rd_go=%0d wr_go=%0d pops=%0d, required 0 0 0",
                     rd_go_cnt, wr_go_cnt, pops);
        end
    endtask

    task automatic test_basic();
        mode = 0; dma_rd_done = 1'b0; dma_wr_done = 1'b0;
        clear_mon();
        do_go(49'd4, 32'd1, 48'h1000, 48'h2000);
        n_checks++;
        if (dma_rd_addr !== 48'h1000 || dma_wr_addr !== 48'h2000 || dma_rd_size !== 49'd4) begin
            n_fail++;
            $display("FAIL basic_latch: rd=%h wr=%h size=%0d, required 1000 2000 4",
                     dma_rd_addr, dma_wr_addr, dma_rd_size);
        end
        wait_writes(4, 60, "basic");
        check_words(4, 0, 32'd1, "basic");
        n_checks++;
        if (first_wr - first_rd != 2) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, required 2", first_wr - first_rd);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_wait: done=%b busy=%b, required done=0 busy=1", done, busy);
        end
        dma_rd_done = 1'b1; dma_wr_done = 1'b1;
        wait_done("basic");
        n_checks++;
        if (rd_go_cnt != 1 || wr_go_cnt != 1 || wq.size() != 4) begin
            n_fail++;
            $display("FAIL basic_pulses: rd_go=%0d wr_go=%0d writes=%0d, required 1 1 4",
                     rd_go_cnt, wr_go_cnt, wq.size());
        end
    endtask

    task automatic test_lane_wrap();
        mode = 1;
        clear_mon();
        do_go(49'd8, 32'hFFFF_FFFF, 48'h10, 48'h20);
        wait_writes(8, 80, "wrap");
        check_words(8, 1, 32'hFFFF_FFFF, "wrap");
        wait_done("wrap");
        mode = 0;
    endtask

    task automatic test_backpressure();
        mode = 0; dma_full = 1'b1;
        clear_mon();
        do_go(49'd16, 32'd5, 48'h30, 48'h40);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (pops != QD || wq.size() != 0) begin
            n_fail++;
            $display("FAIL bp_stall: pops=%0d writes=%0d, required %0d 0", pops, wq.size(), QD);
        end
        dma_full = 1'b0;
        wait_writes(16, 200, "bp");
        check_words(16, 0, 32'd5, "bp");
        wait_done("bp");
    endtask

    task automatic test_go_while_busy();
        dma_full = 1'b1;
        clear_mon();
        do_go(49'd4, 32'd2, 48'h50, 48'h60);
        repeat (2) @(posedge clk);
        #1;
        go = 1'b1; size = 49'd7; rd_addr = 48'h99;
        @(posedge clk); #1;
        go = 1'b0;
        n_checks++;
        if (dma_rd_size !== 49'd4 || dma_rd_addr !== 48'h50 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_go_ignored: size=%0d addr=%h busy=%b, required 4 50 1",
                     dma_rd_size, dma_rd_addr, busy);
        end
        dma_full = 1'b0;
        wait_writes(4, 60, "busygo");
        check_words(4, 0, 32'd2, "busygo");
        wait_done("busygo");
        n_checks++;
        if (rd_go_cnt != 1 || wq.size() != 4) begin
            n_fail++;
            $display("FAIL busygo_count: rd_go=%0d writes=%0d, required 1 4", rd_go_cnt, wq.size());
        end
    endtask

    task automatic test_reset_mid_run();
        clear_mon();
        do_go(49'd16, 32'd7, 48'h70, 48'h80);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, dma_rd_en, dma_wr_en, dma_rd_go, dma_wr_go} !== 6'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: busy,done,rd_en,wr_en,rd_go,wr_go=%b required 000000",
                     {busy, done, dma_rd_en, dma_wr_en, dma_rd_go, dma_wr_go});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        do_go(49'd2, 32'd3, 48'h90, 48'hA0);
        wait_writes(2, 40, "midrst");
        check_words(2, 0, 32'd3, "midrst");
        wait_done("midrst");
    endtask

    initial begin
        go = 1'b0; size = '0; incr = '0; rd_addr = '0; wr_addr = '0;
        dma_empty = 1'b0; dma_full = 1'b0; dma_rd_done = 1'b1; dma_wr_done = 1'b1;
        test_reset();
        test_size0();
        test_basic();
        test_lane_wrap();
        test_backpressure();
        test_go_while_busy();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
